// File: rtl/rng_arbiter.sv
// rng_arbiter: round-robin access to one shared xorshift128 generator,
// with shadowed reseeding, zero-seed guard and warm-up discard.
module rng_arbiter #(
    parameter int N_REQ        = 4,
    parameter int WARMUP_STEPS = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    output logic [N_REQ-1:0] gnt,
    output logic [31:0]      rnd_data,
    output logic             rnd_valid,
    input  logic             seed_we,
    input  logic [1:0]       seed_addr,
    input  logic [31:0]      seed_data,
    input  logic             seed_commit,
    output logic             busy
);
    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [31:0] DEF_X = 32'd123456789;
    localparam logic [31:0] DEF_Y = 32'd362436069;
    localparam logic [31:0] DEF_Z = 32'd521288629;
    localparam logic [31:0] DEF_W = 32'd88675123;
    localparam logic [7:0] WCNT = 8'(WARMUP_STEPS);
    localparam bit NO_WARM = (WARMUP_STEPS == 0);

    typedef enum logic [1:0] {RUN, SEED, WARMUP} state_t;

    state_t state;
    logic [31:0] x, y, z, w;
    logic [31:0] sh [4];
    logic [31:0] shm [4];
    logic [PW-1:0] ptr;
    logic [7:0] cnt;
    logic [31:0] t, nw;
    logic seed_zero;
    logic pick_ok;
    logic [PW-1:0] pick, pick_nxt;
    logic [N_REQ-1:0] pick_oh;

    // next generator word from the live state
    always_comb begin
        t  = x ^ (x << 11);
        nw = w ^ (w >> 19) ^ t ^ (t >> 8);
    end

    // shadow view with this cycle's write merged in, so write+commit lands first
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            shm[i] = (seed_we && seed_addr == 2'(i)) ? seed_data : sh[i];
        end
        seed_zero = ((shm[0] | shm[1] | shm[2] | shm[3]) == 32'd0);
    end

    // round-robin pick: first requester at or above the pointer, wrapping
    always_comb begin
        pick_ok = 1'b0;
        pick    = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_ok && req[(int'(ptr) + k) % N_REQ]) begin
                pick_ok = 1'b1;
                pick    = PW'((int'(ptr) + k) % N_REQ);
            end
        end
        pick_nxt = (int'(pick) == N_REQ - 1) ? '0 : pick + PW'(1);
        pick_oh = '0;
        pick_oh[pick] = 1'b1;
    end

    // sequencer: grants in RUN, shadow writes/commit in SEED, discard in WARMUP
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= RUN;
            x         <= DEF_X;
            y         <= DEF_Y;
            z         <= DEF_Z;
            w         <= DEF_W;
            sh[0]     <= DEF_X;
            sh[1]     <= DEF_Y;
            sh[2]     <= DEF_Z;
            sh[3]     <= DEF_W;
            ptr       <= '0;
            cnt       <= '0;
            gnt       <= '0;
            rnd_data  <= '0;
            rnd_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            gnt       <= '0;
            rnd_valid <= 1'b0;
            unique case (state)
                RUN: begin
                    if (seed_we) begin
                        sh[seed_addr] <= seed_data;
                        state         <= SEED;
                        busy          <= 1'b1;
                    end else if (seed_commit) begin
                        x     <= shm[0];
                        y     <= shm[1];
                        z     <= shm[2];
                        w     <= seed_zero ? DEF_W : shm[3];
                        cnt   <= WCNT;
                        state <= NO_WARM ? RUN : WARMUP;
                        busy  <= !NO_WARM;
                    end else if (pick_ok) begin
                        x         <= y;
                        y         <= z;
                        z         <= w;
                        w         <= nw;
                        gnt       <= pick_oh;
                        rnd_data  <= nw;
                        rnd_valid <= 1'b1;
                        ptr       <= pick_nxt;
                    end
                end
                SEED: begin
                    if (seed_we) begin
                        sh[seed_addr] <= seed_data;
                    end
                    if (seed_commit) begin
                        x     <= shm[0];
                        y     <= shm[1];
                        z     <= shm[2];
                        w     <= seed_zero ? DEF_W : shm[3];
                        cnt   <= WCNT;
                        state <= NO_WARM ? RUN : WARMUP;
                        busy  <= !NO_WARM;
                    end
                end
                WARMUP: begin
                    x   <= y;
                    y   <= z;
                    z   <= w;
                    w   <= nw;
                    cnt <= cnt - 8'd1;
                    if (cnt <= 8'd1) begin
                        state <= RUN;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= RUN;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rng_arbiter.sv
// tb_rng_arbiter: randomized and directed stimulus for rng_arbiter,
// checked by a queue scoreboard fed from a behavioural model.
module tb_rng_arbiter;
    localparam int N  = 4;
    localparam int WS = 16;
    localparam logic [31:0] DX = 32'd123456789;
    localparam logic [31:0] DY = 32'd362436069;
    localparam logic [31:0] DZ = 32'd521288629;
    localparam logic [31:0] DW = 32'd88675123;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [N-1:0] req = '0;
    logic [N-1:0] gnt;
    logic [31:0]  rnd_data;
    logic         rnd_valid;
    logic         seed_we = 1'b0;
    logic [1:0]   seed_addr = '0;
    logic [31:0]  seed_data = '0;
    logic         seed_commit = 1'b0;
    logic         busy;

    always #5 clk = ~clk;

    rng_arbiter #(.N_REQ(N), .WARMUP_STEPS(WS)) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .gnt         (gnt),
        .rnd_data    (rnd_data),
        .rnd_valid   (rnd_valid),
        .seed_we     (seed_we),
        .seed_addr   (seed_addr),
        .seed_data   (seed_data),
        .seed_commit (seed_commit),
        .busy        (busy)
    );

    typedef struct { int stamp; logic [N-1:0] g; logic [31:0] d; } exp_t;
    typedef struct { int stamp; logic b; } bexp_t;

    exp_t        eq[$];
    bexp_t       bq[$];
    logic [31:0] seen_d[$];
    logic [N-1:0] seen_g[$];
    int cyc   = 0;
    int total = 0;
    int bad   = 0;

    // behavioural model: generator words, shadow, mode 0=run 1=seed 2=warm-up
    logic [31:0] mx, my, mz, mw;
    logic [31:0] msh [4];
    int mode, mptr, mcnt;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_seen(input string name, input int idx, input logic [31:0] exp);
        if (idx < seen_d.size()) chk(name, seen_d[idx], exp);
        else begin
            total++;
            bad++;
            $display("FAIL %s: got no word expected %0d", name, exp);
        end
    endtask

    task automatic chk_gnt(input string name, input int idx, input logic [N-1:0] exp);
        if (idx < seen_g.size()) chk(name, 32'(seen_g[idx]), 32'(exp));
        else begin
            total++;
            bad++;
            $display("FAIL %s: got no grant expected %0d", name, exp);
        end
    endtask

    function automatic void model_reset();
        mx = DX; my = DY; mz = DZ; mw = DW;
        msh[0] = DX; msh[1] = DY; msh[2] = DZ; msh[3] = DW;
        mode = 0; mptr = 0; mcnt = 0;
    endfunction

    function automatic void mstep();
        logic [31:0] tt, nn;
        tt = mx ^ (mx << 11);
        nn = mw ^ (mw >> 19) ^ tt ^ (tt >> 8);
        mx = my; my = mz; mz = mw; mw = nn;
    endfunction

    function automatic void mcommit();
        mx = msh[0]; my = msh[1]; mz = msh[2]; mw = msh[3];
        if ((msh[0] | msh[1] | msh[2] | msh[3]) == 0) mw = DW;
        if (WS == 0) mode = 0;
        else begin
            mode = 2;
            mcnt = WS;
        end
    endfunction

    // apply one cycle of inputs, predict its effect, then advance one edge
    task automatic drive(input logic [N-1:0] r, input logic we, input logic [1:0] a,
                         input logic [31:0] d, input logic cm, output int granted);
        logic [N-1:0] gv;
        granted = -1;
        req = r; seed_we = we; seed_addr = a; seed_data = d; seed_commit = cm;
        if (mode == 0) begin
            if (we) begin
                msh[a] = d;
                mode = 1;
            end else if (cm) mcommit();
            else if (r != 0) begin
                for (int k = 0; k < N; k++)
                    if (granted < 0 && r[(mptr + k) % N]) granted = (mptr + k) % N;
                mstep();
                gv = 1;
                gv = gv << granted;
                eq.push_back('{cyc + 1, gv, mw});
                mptr = (granted + 1) % N;
            end
        end else if (mode == 1) begin
            if (we) msh[a] = d;
            if (cm) mcommit();
        end else begin
            mstep();
            mcnt--;
            if (mcnt == 0) mode = 0;
        end
        bq.push_back('{cyc + 1, mode != 0});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        int g;
        drive('0, 1'b0, 2'd0, 32'd0, 1'b0, g);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        eq.delete();
        bq.delete();
        model_reset();
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(rnd_valid), 0);
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_data", rnd_data, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // monitor: pop expectations as the DUT presents words
    always @(negedge clk) begin
        if (!rst) begin
            while (eq.size() > 0 && eq[0].stamp < cyc) begin
                total++;
                bad++;
                $display("FAIL missed_grant: got none expected gnt=%b data=%0d",
                         eq[0].g, eq[0].d);
                void'(eq.pop_front());
            end
            if (rnd_valid === 1'b1) begin
                seen_d.push_back(rnd_data);
                seen_g.push_back(gnt);
                if (eq.size() == 0 || eq[0].stamp != cyc) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_grant: got gnt=%b data=%0d expected none",
                             gnt, rnd_data);
                end else begin
                    exp_t e;
                    e = eq.pop_front();
                    chk("grant_vec", 32'(gnt), 32'(e.g));
                    chk("grant_data", rnd_data, e.d);
                end
            end else begin
                chk("idle_gnt", 32'(gnt), 0);
            end
            while (bq.size() > 0 && bq[0].stamp < cyc) void'(bq.pop_front());
            if (bq.size() > 0 && bq[0].stamp == cyc) begin
                bexp_t b;
                b = bq.pop_front();
                chk("busy", 32'(busy), 32'(b.b));
            end
        end
    end

    initial begin
        int g, s, n;
        logic [N-1:0] pend, e;
        logic we, cm;
        logic [1:0] a;
        logic [31:0] d;

        model_reset();
        do_reset();

        // three back-to-back grants to requester 0 from the default seed
        s = seen_d.size();
        repeat (3) drive(4'b0001, 1'b0, 2'd0, 32'd0, 1'b0, g);
        idle();
        chk_seen("t1_w0", s, 32'd3701687786);
        chk_seen("t1_w1", s + 1, 32'd458299110);
        chk_seen("t1_w2", s + 2, 32'd2500872618);

        // all requesting: strict rotation
        do_reset();
        s = seen_g.size();
        repeat (8) drive(4'b1111, 1'b0, 2'd0, 32'd0, 1'b0, g);
        idle();
        for (int i = 0; i < 8; i++) begin
            e = 4'b0001;
            e = e << (i % 4);
            chk_gnt("t2_rot", s + i, e);
        end

        // pointer skips idle requesters and wraps
        do_reset();
        s = seen_g.size();
        drive(4'b0001, 1'b0, 2'd0, 32'd0, 1'b0, g);
        drive(4'b0101, 1'b0, 2'd0, 32'd0, 1'b0, g);
        drive(4'b0101, 1'b0, 2'd0, 32'd0, 1'b0, g);
        idle();
        chk_gnt("t3_g0", s, 4'b0001);
        chk_gnt("t3_g1", s + 1, 4'b0100);
        chk_gnt("t3_g2", s + 2, 4'b0001);

        // reseed with defaults, separate commit, warm-up then grant
        drive('0, 1'b1, 2'd0, DX, 1'b0, g);
        drive('0, 1'b1, 2'd1, DY, 1'b0, g);
        drive(4'b0001, 1'b1, 2'd2, DZ, 1'b0, g);
        drive(4'b0001, 1'b1, 2'd3, DW, 1'b0, g);
        drive(4'b0001, 1'b0, 2'd0, 32'd0, 1'b1, g);
        repeat (WS) idle();
        chk("t4_busy_done", 32'(busy), 0);
        drive(4'b0001, 1'b0, 2'd0, 32'd0, 1'b0, g);
        idle();

        // all-zero seed with write and commit in the same cycle
        drive('0, 1'b1, 2'd0, 32'd0, 1'b0, g);
        drive('0, 1'b1, 2'd1, 32'd0, 1'b0, g);
        drive('0, 1'b1, 2'd2, 32'd0, 1'b0, g);
        drive('0, 1'b1, 2'd3, 32'd0, 1'b1, g);
        n = 1;
        while (busy === 1'b1 && n < 40) begin
            idle();
            n++;
        end
        chk("t5_busy_cycles", n, WS + 1);
        s = seen_d.size();
        drive(4'b0010, 1'b0, 2'd0, 32'd0, 1'b0, g);
        idle();
        total++;
        if (s >= seen_d.size() || seen_d[s] == 0) begin
            bad++;
            $display("FAIL t5_nonzero: got zero or no word expected nonzero");
        end

        // reset in the middle of warm-up with a request held
        drive(4'b0001, 1'b0, 2'd0, 32'd0, 1'b1, g);
        repeat (5) drive(4'b0001, 1'b0, 2'd0, 32'd0, 1'b0, g);
        do_reset();
        s = seen_d.size();
        drive(4'b0001, 1'b0, 2'd0, 32'd0, 1'b0, g);
        idle();
        chk_seen("t6_first", s, 32'd3701687786);

        // randomized traffic with occasional reseeding
        pend = '0;
        for (int i = 0; i < 600; i++) begin
            pend = pend | (N'($urandom_range(0, 15)) & N'($urandom_range(0, 15)));
            we = ($urandom_range(0, 29) == 0);
            cm = (mode == 1) ? ($urandom_range(0, 5) == 0)
                             : ($urandom_range(0, 59) == 0);
            if (mode == 0 && we) cm = 1'b0;
            a = 2'($urandom_range(0, 3));
            d = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            drive(pend, we, a, d, cm, g);
            if (g >= 0) pend[g] = 1'b0;
        end
        idle();
        idle();
        chk("drained", eq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
